// File: rtl/matrix_mac_engine_if.sv
// rtl/matrix_mac_engine_if.sv - operand/result handshake bundle for matrix_mac_engine
interface matrix_mac_engine_if #(
  parameter int N  = 2,
  parameter int W  = 32,
  parameter int OW = 2 * W + $clog2(N)
);
  logic                start;
  logic                accumulate;
  logic [N*N*W-1:0]    mat_a;
  logic [N*N*W-1:0]    mat_b;
  logic                out_ack;
  logic [N*N*OW-1:0]   out_matrix;
  logic                out_ready;
  logic                busy;
  logic                overflow;

  modport master (
    output start, accumulate, mat_a, mat_b, out_ack,
    input  out_matrix, out_ready, busy, overflow
  );

  modport slave (
    input  start, accumulate, mat_a, mat_b, out_ack,
    output out_matrix, out_ready, busy, overflow
  );
endinterface

// File: rtl/matrix_mac_engine.sv
// rtl/matrix_mac_engine.sv - sequential N x N signed matrix multiply-accumulate engine
module matrix_mac_engine #(
  parameter int N  = 2,
  parameter int W  = 32,
  parameter int OW = 2 * W + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  matrix_mac_engine_if.slave      io
);
  localparam int AW = 2 * W + $clog2(N);
  localparam int TW = AW + 1;
  localparam int CW = $clog2(N);
  localparam int IW = $clog2(N * N);

  localparam logic signed [TW-1:0] SAT_MAX = {{(TW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [TW-1:0] SAT_MIN = {{(TW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  logic [N*N*W-1:0]        a_reg;
  logic [N*N*W-1:0]        b_reg;
  logic                    acc_mode;
  logic [CW-1:0]           i_cnt, j_cnt, k_cnt;
  logic signed [AW-1:0]    acc;
  logic signed [OW-1:0]    c_reg [N*N];
  logic                    ovf;
  logic                    calc_done;

  logic [IW-1:0]           a_idx, b_idx, c_idx;
  logic signed [W-1:0]     a_elem, b_elem;
  logic signed [2*W-1:0]   prod;
  logic signed [AW-1:0]    sum;
  logic signed [TW-1:0]    prev_ext;
  logic signed [TW-1:0]    total;
  logic                    sat_hi, sat_lo;
  logic signed [OW-1:0]    wr_val;
  logic                    k_last, j_last, i_last;

  always_comb begin
    a_idx  = IW'(i_cnt) * IW'(N) + IW'(k_cnt);
    b_idx  = IW'(k_cnt) * IW'(N) + IW'(j_cnt);
    c_idx  = IW'(i_cnt) * IW'(N) + IW'(j_cnt);
    a_elem = a_reg[a_idx*W +: W];
    b_elem = b_reg[b_idx*W +: W];
    prod   = a_elem * b_elem;
    sum    = acc + AW'(prod);
  end

  // In accumulate mode the held result element is folded into the final sum.
  always_comb begin
    prev_ext = '0;
    if (acc_mode) begin
      prev_ext = TW'(c_reg[c_idx]);
    end
    total  = TW'(sum) + prev_ext;
    sat_hi = total > SAT_MAX;
    sat_lo = total < SAT_MIN;
    if (sat_hi) begin
      wr_val = SAT_MAX[OW-1:0];
    end else if (sat_lo) begin
      wr_val = SAT_MIN[OW-1:0];
    end else begin
      wr_val = total[OW-1:0];
    end
  end

  assign k_last = (k_cnt == CW'(N - 1));
  assign j_last = (j_cnt == CW'(N - 1));
  assign i_last = (i_cnt == CW'(N - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (io.start)   state_next = CALC;
      CALC:    if (calc_done)  state_next = DONE;
      DONE:    if (io.out_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // calc_done gives the extra cycle between the last element write and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc_mode  <= 1'b0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      k_cnt     <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      calc_done <= 1'b0;
      for (int e = 0; e < N * N; e++) begin
        c_reg[e] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (io.start) begin
            a_reg     <= io.mat_a;
            b_reg     <= io.mat_b;
            acc_mode  <= io.accumulate;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            calc_done <= 1'b0;
          end
        end
        CALC: begin
          if (!calc_done) begin
            if (k_last) begin
              c_reg[c_idx] <= wr_val;
              ovf          <= ovf | sat_hi | sat_lo;
              acc          <= '0;
              k_cnt        <= '0;
              if (j_last) begin
                j_cnt <= '0;
                if (i_last) begin
                  i_cnt     <= '0;
                  calc_done <= 1'b1;
                end else begin
                  i_cnt <= i_cnt + 1'b1;
                end
              end else begin
                j_cnt <= j_cnt + 1'b1;
              end
            end else begin
              acc   <= sum;
              k_cnt <= k_cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar e = 0; e < N * N; e++) begin : g_out
    assign io.out_matrix[e*OW +: OW] = c_reg[e];
  end

  assign io.busy      = (state != IDLE);
  assign io.out_ready = (state == DONE);
  assign io.overflow  = ovf;
endmodule

// File: tb/tb_matrix_mac_engine.sv
// tb/tb_matrix_mac_engine.sv - scoreboard bench for matrix_mac_engine (N=2, W=8, OW=8)
module tb_matrix_mac_engine;
  localparam int N  = 2;
  localparam int W  = 8;
  localparam int OW = 8;
  localparam int LAT = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_mac_engine_if #(.N(N), .W(W), .OW(OW)) io ();
  matrix_mac_engine #(.N(N), .W(W), .OW(OW)) dut (.clk(clk), .rst(rst), .io(io));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] mat;
    logic        ovf;
    int          start_edge;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t cur;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pk(int e00, int e01, int e10, int e11);
    logic [7:0] a, b, c, d;
    a = e00[7:0];
    b = e01[7:0];
    c = e10[7:0];
    d = e11[7:0];
    return {d, c, b, a};
  endfunction

  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (io.out_ready && !prev_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: actual out_matrix 0x%0h required no result", io.out_matrix);
      end else begin
        cur = sb.pop_front();
        check({cur.name, "_matrix"}, 64'(io.out_matrix), 64'(cur.mat));
        check({cur.name, "_overflow"}, 64'(io.overflow), 64'(cur.ovf));
        check({cur.name, "_latency"}, 64'(cyc - cur.start_edge), 64'(LAT));
      end
    end
    prev_ready = io.out_ready;
  end

  task automatic start_op(logic [31:0] a, logic [31:0] b, logic acc);
    io.mat_a      = a;
    io.mat_b      = b;
    io.accumulate = acc;
    io.start      = 1'b1;
    @(negedge clk);
    io.start      = 1'b0;
  endtask

  task automatic expect_op(string name, logic [31:0] a, logic [31:0] b, logic acc,
                           logic [31:0] res, logic ov);
    sb.push_back('{mat: res, ovf: ov, start_edge: cyc + 1, name: name});
    start_op(a, b, acc);
  endtask

  task automatic wait_ready(string name);
    int n;
    n = 0;
    while (!io.out_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!io.out_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: actual out_ready 0 required 1 within 40 cycles", name);
    end
  endtask

  task automatic ack(string name);
    io.out_ack = 1'b1;
    @(negedge clk);
    io.out_ack = 1'b0;
    check({name, "_ack_busy"}, 64'(io.busy), 64'd0);
  endtask

  task automatic run(string name, logic [31:0] a, logic [31:0] b, logic acc,
                     logic [31:0] res, logic ov);
    expect_op(name, a, b, acc, res, ov);
    wait_ready(name);
    ack(name);
  endtask

  logic [31:0] a1, b1, c1;

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required completion");
    $fatal(1);
  end

  initial begin
    a1 = pk(1, 2, 3, 4);
    b1 = pk(5, 6, 7, 8);
    c1 = pk(19, 22, 43, 50);

    rst           = 1'b1;
    io.start      = 1'b0;
    io.out_ack    = 1'b0;
    io.accumulate = 1'b0;
    io.mat_a      = '0;
    io.mat_b      = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(io.busy), 64'd0);
    check("reset_out_ready", 64'(io.out_ready), 64'd0);
    check("reset_overflow", 64'(io.overflow), 64'd0);
    check("reset_matrix", 64'(io.out_matrix), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Operand changes and a start pulse during CALC must not disturb the result.
    expect_op("basic", a1, b1, 1'b0, c1, 1'b0);
    io.mat_a      = pk(9, 9, 9, 9);
    io.mat_b      = pk(-3, -3, -3, -3);
    io.accumulate = 1'b1;
    @(negedge clk);
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    check("calc_busy", 64'(io.busy), 64'd1);
    wait_ready("basic");
    for (int i = 0; i < 10; i++) begin
      io.start = (i == 3);
      @(negedge clk);
      check("hold_ready", 64'(io.out_ready), 64'd1);
      check("hold_matrix", 64'(io.out_matrix), 64'(c1));
    end
    io.start   = 1'b1;
    io.out_ack = 1'b1;
    @(negedge clk);
    io.start   = 1'b0;
    io.out_ack = 1'b0;
    check("ack_start_busy", 64'(io.busy), 64'd0);
    check("ack_out_ready", 64'(io.out_ready), 64'd0);
    check("idle_keeps_matrix", 64'(io.out_matrix), 64'(c1));

    run("signed", pk(-1, 0, 0, -1), pk(5, -6, 7, 8), 1'b0, pk(-5, 6, -7, -8), 1'b0);
    run("basic2", a1, b1, 1'b0, c1, 1'b0);
    run("accum", a1, b1, 1'b1, pk(38, 44, 86, 100), 1'b0);
    run("sat_pos", pk(127, 127, 127, 127), pk(127, 127, 127, 127), 1'b0,
        pk(127, 127, 127, 127), 1'b1);
    run("sat_neg", pk(-128, -128, -128, -128), pk(127, 127, 127, 127), 1'b0,
        pk(-128, -128, -128, -128), 1'b1);
    run("ovf_clear", a1, b1, 1'b0, c1, 1'b0);

    // Saturating operands so overflow is already set when reset lands mid-CALC.
    start_op(pk(127, 127, 127, 127), pk(127, 127, 127, 127), 1'b0);
    repeat (3) @(negedge clk);
    check("midcalc_overflow", 64'(io.overflow), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_busy", 64'(io.busy), 64'd0);
    check("midreset_out_ready", 64'(io.out_ready), 64'd0);
    check("midreset_overflow", 64'(io.overflow), 64'd0);
    check("midreset_matrix", 64'(io.out_matrix), 64'd0);

    run("after_reset", a1, b1, 1'b0, c1, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
